// File: rtl/ship_life_ctrl.sv
// Player ship life controller: lives, explosion animation, respawn
// invulnerability with blinking, and game-over handling.
module ship_life_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned EXPLODE_STEP  = 4,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       game_start,
  output logic [1:0] lives,
  output logic       ship_visible,
  output logic       ship_enable,
  output logic       hit_mask,
  output logic       explosion_active,
  output logic [2:0] explosion_frame,
  output logic       life_lost,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    EXPLODE,
    INVULN,
    GAME_OVER
  } state_t;

  // Counters compare against "last tick" values so each phase spans exactly N ticks.
  localparam logic [1:0] LIVES_LOAD  = 2'(LIVES_INIT);
  localparam logic [7:0] STEP_LAST   = 8'(EXPLODE_STEP - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

  state_t     state_reg;
  logic [7:0] step_cnt_reg;
  logic [7:0] invuln_cnt_reg;
  logic [7:0] blink_cnt_reg;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg        <= IDLE;
      lives            <= LIVES_LOAD;
      ship_visible     <= 1'b0;
      ship_enable      <= 1'b0;
      hit_mask         <= 1'b1;
      explosion_active <= 1'b0;
      explosion_frame  <= 3'd0;
      life_lost        <= 1'b0;
      game_over        <= 1'b0;
      step_cnt_reg     <= 8'd0;
      invuln_cnt_reg   <= 8'd0;
      blink_cnt_reg    <= 8'd0;
    end else begin
      life_lost <= 1'b0;
      case (state_reg)
        IDLE, GAME_OVER: begin
          if (game_start) begin
            state_reg      <= ALIVE;
            lives          <= LIVES_LOAD;
            ship_visible   <= 1'b1;
            ship_enable    <= 1'b1;
            hit_mask       <= 1'b0;
            game_over      <= 1'b0;
            step_cnt_reg   <= 8'd0;
            invuln_cnt_reg <= 8'd0;
            blink_cnt_reg  <= 8'd0;
          end
        end

        // A coincident frame_tick is deliberately dropped when hit wins.
        ALIVE: begin
          if (hit) begin
            state_reg        <= EXPLODE;
            if (lives != 2'd0) lives <= lives - 2'd1;
            life_lost        <= 1'b1;
            ship_visible     <= 1'b0;
            ship_enable      <= 1'b0;
            hit_mask         <= 1'b1;
            explosion_active <= 1'b1;
            explosion_frame  <= 3'd0;
            step_cnt_reg     <= 8'd0;
            invuln_cnt_reg   <= 8'd0;
            blink_cnt_reg    <= 8'd0;
          end
        end

        EXPLODE: begin
          if (frame_tick) begin
            if (step_cnt_reg == STEP_LAST) begin
              step_cnt_reg <= 8'd0;
              if (explosion_frame == 3'd7) begin
                explosion_active <= 1'b0;
                explosion_frame  <= 3'd0;
                invuln_cnt_reg   <= 8'd0;
                blink_cnt_reg    <= 8'd0;
                if (lives == 2'd0) begin
                  state_reg    <= GAME_OVER;
                  game_over    <= 1'b1;
                  ship_visible <= 1'b0;
                  ship_enable  <= 1'b0;
                  hit_mask     <= 1'b1;
                end else begin
                  state_reg    <= INVULN;
                  ship_visible <= 1'b1;
                  ship_enable  <= 1'b1;
                  hit_mask     <= 1'b1;
                end
              end else begin
                explosion_frame <= explosion_frame + 3'd1;
              end
            end else begin
              step_cnt_reg <= step_cnt_reg + 8'd1;
            end
          end
        end

        INVULN: begin
          if (frame_tick) begin
            if (invuln_cnt_reg == INVULN_LAST) begin
              state_reg      <= ALIVE;
              ship_visible   <= 1'b1;
              ship_enable    <= 1'b1;
              hit_mask       <= 1'b0;
              invuln_cnt_reg <= 8'd0;
              blink_cnt_reg  <= 8'd0;
              step_cnt_reg   <= 8'd0;
            end else begin
              invuln_cnt_reg <= invuln_cnt_reg + 8'd1;
              if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= 8'd0;
                ship_visible  <= ~ship_visible;
              end else begin
                blink_cnt_reg <= blink_cnt_reg + 8'd1;
              end
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
